bpu_sequencer: RTL and testbench

//  Issue side of the butterfly datapath: walks a radix-2 DIT in-place FFT of N points,

---
 rtl/bpu_sequencer.sv | 147 ++++++++++++++
 tb/tb_bpu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_sequencer.sv
// Issue-side sequencer for an in-place radix-2 DIT FFT: walks (stage, butterfly) pairs,
// emits operand addresses and twiddle index, and inserts a drain gap between stages.
module bpu_sequencer #(
    parameter int unsigned N            = 32,
    parameter int unsigned address_size = $clog2(N),
    parameter int unsigned drain_cycles = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              en,
    output logic [address_size-1:0]           rd_address1,
    output logic [address_size-1:0]           rd_address2,
    output logic [address_size-2:0]           tw_address,
    output logic                              rd_valid,
    output logic [$clog2(address_size)-1:0]   stage,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned AW = address_size;
    localparam int unsigned SW = $clog2(address_size);
    localparam int unsigned KW = address_size - 1;
    localparam int unsigned DW = $clog2(drain_cycles + 1);

    localparam logic [KW-1:0] K_LAST     = KW'(N / 2 - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(drain_cycles - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(AW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t          state, state_d;
    logic [KW-1:0]   k, k_d;
    logic [DW-1:0]   drain_cnt, drain_d;
    logic [SW-1:0]   stage_d;
    logic [AW-1:0]   addr1_d, addr2_d;
    logic [AW-2:0]   tw_d;
    logic            valid_d, busy_d, done_d;

    // Butterfly operand addresses and twiddle index for the current (stage, k)
    logic [AW-1:0]   k_ext, span, pos, grp, addr_a, addr_b;
    logic [AW-2:0]   tw_idx;
    logic [SW-1:0]   tw_shift;

    always_comb begin
        k_ext    = AW'(k);
        span     = AW'(1) << stage;
        pos      = k_ext & (span - AW'(1));
        grp      = k_ext >> stage;
        addr_a   = ((grp << stage) << 1) | pos;
        addr_b   = addr_a + span;
        tw_shift = STAGE_LAST - stage;
        tw_idx   = (AW-1)'(pos << tw_shift);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        k_d     = k;
        drain_d = drain_cnt;
        stage_d = stage;
        addr1_d = rd_address1;
        addr2_d = rd_address2;
        tw_d    = tw_address;
        valid_d = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    busy_d  = 1'b1;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            S_ISSUE: begin
                if (en) begin
                    addr1_d = addr_a;
                    addr2_d = addr_b;
                    tw_d    = tw_idx;
                    valid_d = 1'b1;
                    if (k == K_LAST) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                        k_d     = '0;
                    end else begin
                        k_d = k + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Drain runs regardless of en so writeback of this stage always completes
                if (drain_cnt == DRAIN_LAST) begin
                    if (stage == STAGE_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        stage_d = stage + SW'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    drain_d = drain_cnt + DW'(1);
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                stage_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            k           <= '0;
            drain_cnt   <= '0;
            stage       <= '0;
            rd_address1 <= '0;
            rd_address2 <= '0;
            tw_address  <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            k           <= k_d;
            drain_cnt   <= drain_d;
            stage       <= stage_d;
            rd_address1 <= addr1_d;
            rd_address2 <= addr2_d;
            tw_address  <= tw_d;
            rd_valid    <= valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_bpu_sequencer.sv
// Scoreboard bench for bpu_sequencer: N=32 and N=8 instances, expected issue streams
// queued at start, compared by a negedge monitor together with gap/done timing checks.
module tb_bpu_sequencer;

    localparam int DRAIN = 4;

    typedef struct packed {
        int a1;
        int a2;
        int tw;
        int st;
    } tup_t;

    logic clk = 1'b0;
    logic reset;
    logic start32, en32, start8, en8;

    logic [4:0] a1_32, a2_32;
    logic [3:0] tw_32;
    logic [2:0] st_32;
    logic       v32, busy32, done32;

    logic [2:0] a1_8, a2_8;
    logic [1:0] tw_8;
    logic [1:0] st_8;
    logic       v8, busy8, done8;

    always #5 clk = ~clk;

    bpu_sequencer #(.N(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .en(en32),
        .rd_address1(a1_32), .rd_address2(a2_32), .tw_address(tw_32),
        .rd_valid(v32), .stage(st_32), .busy(busy32), .done(done32)
    );

    bpu_sequencer #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .en(en8),
        .rd_address1(a1_8), .rd_address2(a2_8), .tw_address(tw_8),
        .rd_valid(v8), .stage(st_8), .busy(busy8), .done(done8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    tup_t q0[$];
    tup_t q1[$];
    int   cyc[2], last_v[2], last_st[2], k_obs[2], pulses[2], dones[2], exp_total[2];
    bit   have_last[2], stall_allow[2];

    // Hand-computed vectors: inst(0=N32,1=N8), stage, k, a1, a2, tw
    int hand [12][6] = '{
        '{0, 0,  0,  0,  1,  0}, '{0, 0,  1,  2,  3,  0}, '{0, 0,  2,  4,  5,  0},
        '{0, 1,  1,  1,  3,  8}, '{0, 2,  3,  3,  7, 12}, '{0, 3,  9, 17, 25,  2},
        '{0, 4,  5,  5, 21,  5}, '{0, 4, 15, 15, 31, 15}, '{1, 1,  3,  5,  7,  2},
        '{1, 2,  0,  0,  4,  0}, '{1, 2,  1,  1,  5,  1}, '{1, 2,  3,  3,  7,  3}
    };

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inst(input int inst);
        if (inst == 0) q0.delete(); else q1.delete();
        have_last[inst]   = 1'b0;
        stall_allow[inst] = 1'b0;
        pulses[inst]      = 0;
        dones[inst]       = 0;
        k_obs[inst]       = 0;
        exp_total[inst]   = 0;
    endtask

    // Expected stream: groups of 2h points, butterflies (g*2h+p, g*2h+p+h), twiddle p*N/(2h)
    task automatic push_run(input int inst, input int n);
        int   stages;
        tup_t t;
        stages = $clog2(n);
        for (int s = 0; s < stages; s++) begin
            int h;
            h = 1 << s;
            for (int g = 0; g < n / (2 * h); g++) begin
                for (int p = 0; p < h; p++) begin
                    t.a1 = g * 2 * h + p;
                    t.a2 = t.a1 + h;
                    t.tw = p * (n / (2 * h));
                    t.st = s;
                    if (inst == 0) q0.push_back(t); else q1.push_back(t);
                    exp_total[inst]++;
                end
            end
        end
    endtask

    task automatic mon(input int inst, input logic v, input int a1, input int a2,
                       input int tw, input int st, input logic d, input logic b);
        string pfx;
        tup_t  e;
        int    gap;
        bit    have_exp;
        pfx = (inst == 0) ? "n32" : "n8";
        cyc[inst]++;
        if (v) begin
            if (have_last[inst]) begin
                gap = cyc[inst] - last_v[inst] - 1;
                if (st != last_st[inst]) chk({pfx, "_stage_gap"}, gap, DRAIN);
                else if (stall_allow[inst] && gap != 0) begin
                    chk({pfx, "_stall_gap"}, gap, 3);
                    stall_allow[inst] = 1'b0;
                end else chk({pfx, "_issue_gap"}, gap, 0);
            end
            k_obs[inst] = (have_last[inst] && st == last_st[inst]) ? k_obs[inst] + 1 : 0;
            have_exp = (inst == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have_exp) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_unexpected_pulse: got (%0d,%0d,%0d) st %0d, want no pulse",
                         pfx, a1, a2, tw, st);
            end else begin
                e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                chk({pfx, "_stage"}, st, e.st);
                chk({pfx, "_a1"}, a1, e.a1);
                chk({pfx, "_a2"}, a2, e.a2);
                chk({pfx, "_tw"}, tw, e.tw);
            end
            for (int i = 0; i < 12; i++) begin
                if (hand[i][0] == inst && hand[i][1] == st && hand[i][2] == k_obs[inst]) begin
                    chk({pfx, "_hand_a1"}, a1, hand[i][3]);
                    chk({pfx, "_hand_a2"}, a2, hand[i][4]);
                    chk({pfx, "_hand_tw"}, tw, hand[i][5]);
                end
            end
            pulses[inst]++;
            last_v[inst]    = cyc[inst];
            last_st[inst]   = st;
            have_last[inst] = 1'b1;
        end
        if (d) begin
            dones[inst]++;
            chk({pfx, "_busy_at_done"}, int'(b), 0);
            chk({pfx, "_done_delay"}, cyc[inst] - last_v[inst], DRAIN + 1);
            chk({pfx, "_pulses_at_done"}, pulses[inst], exp_total[inst]);
            chk({pfx, "_queue_left"}, (inst == 0) ? q0.size() : q1.size(), 0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, v32, int'(a1_32), int'(a2_32), int'(tw_32), int'(st_32), done32, busy32);
            mon(1, v8, int'(a1_8), int'(a2_8), int'(tw_8), int'(st_8), done8, busy8);
        end
    end

    task automatic wait_done(input int inst, input int budget);
        int  n;
        logic d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            d = (inst == 0) ? done32 : done8;
        end while (!d && n < budget);
        if (!d) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout inst %0d: got no done in %0d cycles, want done", inst, budget);
        end
    endtask

    task automatic start_run32();
        clear_inst(0);
        push_run(0, 32);
        @(posedge clk); #1 start32 = 1'b1;
        @(posedge clk); #1 start32 = 1'b0;
    endtask

    task automatic check_idle_after(input int inst, input int exp_pulses);
        repeat (20) @(negedge clk);
        chk($sformatf("inst%0d_dones", inst), dones[inst], 1);
        chk($sformatf("inst%0d_pulses", inst), pulses[inst], exp_pulses);
        chk($sformatf("inst%0d_busy_idle", inst), int'((inst == 0) ? busy32 : busy8), 0);
    endtask

    task automatic check_zero32(input string tag);
        chk({tag, "_a1"}, int'(a1_32), 0);
        chk({tag, "_a2"}, int'(a2_32), 0);
        chk({tag, "_tw"}, int'(tw_32), 0);
        chk({tag, "_stage"}, int'(st_32), 0);
        chk({tag, "_valid"}, int'(v32), 0);
        chk({tag, "_busy"}, int'(busy32), 0);
        chk({tag, "_done"}, int'(done32), 0);
    endtask

    initial begin
        int n;
        reset = 1'b0; start32 = 1'b0; en32 = 1'b1; start8 = 1'b0; en8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 0; last_v[i] = 0; last_st[i] = 0;
            clear_inst(i);
        end
        #1 reset = 1'b1;
        #2;
        check_zero32("reset32");
        chk("reset8_valid", int'(v8), 0);
        chk("reset8_busy", int'(busy8), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Plain run, with a second start pulse mid-transform that must be ignored
        chk("busy_before_start", int'(busy32), 0);
        start_run32();
        chk("busy_after_start", int'(busy32), 1);
        chk("valid_after_start", int'(v32), 0);
        repeat (30) @(posedge clk);
        #1 start32 = 1'b1;
        @(posedge clk); #1 start32 = 1'b0;
        wait_done(0, 1000);
        check_idle_after(0, 80);

        // Three-cycle issue stall in the middle of stage 2
        start_run32();
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(v32 && st_32 == 3'd2 && a1_32 == 5'd2) && n < 500);
        chk("stall_point_found", int'(v32 && st_32 == 3'd2 && a1_32 == 5'd2), 1);
        stall_allow[0] = 1'b1;
        @(posedge clk); #1 en32 = 1'b0;
        repeat (3) @(posedge clk);
        #1 en32 = 1'b1;
        wait_done(0, 1000);
        check_idle_after(0, 80);
        chk("stall_consumed", int'(stall_allow[0]), 0);

        // Asynchronous reset during the stage-3 drain, then a clean transform
        start_run32();
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(st_32 == 3'd3 && !v32 && busy32 && pulses[0] == 64) && n < 500);
        chk("drain3_found", pulses[0], 64);
        #2 reset = 1'b1;
        #1 check_zero32("midreset");
        clear_inst(0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start_run32();
        wait_done(0, 1000);
        check_idle_after(0, 80);

        // N=8 with start held high until done: one transform only
        clear_inst(1);
        push_run(1, 8);
        @(posedge clk); #1 start8 = 1'b1;
        wait_done(1, 500);
        #1 start8 = 1'b0;
        check_idle_after(1, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
